// File: rtl/display_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : display_mode_ctrl
// Brief    : Debounced keypad control of display mode and threshold; requests
//            are committed to the outputs only inside camera vertical blanking.
// Revision : 1.0
// ============================================================================
module display_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BLANK_WAIT      = 50,
  parameter int THRESH_STEP     = 8,
  parameter int THRESH_INIT     = 128
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iFval,
  input  logic       iKey_next,
  input  logic       iKey_prev,
  input  logic       iKey_up,
  input  logic       iKey_down,
  output logic [2:0] oSelect,
  output logic [7:0] oThreshold,
  output logic       oSwitch_pulse,
  output logic       oPending
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int BL_W = (BLANK_WAIT > 1) ? $clog2(BLANK_WAIT) : 1;

  localparam logic [DB_W-1:0] c_DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BL_W-1:0] c_BL_LAST = BL_W'(BLANK_WAIT - 1);
  localparam logic [8:0]      c_STEP9   = 9'(THRESH_STEP);
  localparam logic [7:0]      c_STEP8   = 8'(THRESH_STEP);
  localparam logic [7:0]      c_THR0    = 8'(THRESH_INIT);

  localparam logic [1:0] c_HOLD  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_BLANK = 2'd2;

  // Key order: [0]=next, [1]=prev, [2]=up, [3]=down
  logic [3:0] w_key_raw;
  logic [3:0] w_press;

  assign w_key_raw = {iKey_down, iKey_up, iKey_prev, iKey_next};

  for (genvar k = 0; k < 4; k++) begin : g_key
    logic            meta_q;
    logic            sync_q;
    logic            acc_q;
    logic            press_q;
    logic [DB_W-1:0] cnt_q;
    logic            w_flip;

    // Accepted level flips on the DEBOUNCE_CYCLES-th consecutive differing cycle
    assign w_flip = (sync_q != acc_q) && (cnt_q == c_DB_LAST);

    always_ff @(posedge iClk) begin
      if (!iRst_n) begin
        meta_q  <= 1'b1;
        sync_q  <= 1'b1;
        acc_q   <= 1'b1;
        press_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        meta_q  <= w_key_raw[k];
        sync_q  <= meta_q;
        press_q <= w_flip && acc_q;
        if (sync_q == acc_q) begin
          cnt_q <= '0;
        end else if (w_flip) begin
          cnt_q <= '0;
          acc_q <= sync_q;
        end else begin
          cnt_q <= cnt_q + DB_W'(1);
        end
      end
    end

    assign w_press[k] = press_q;
  end

  logic w_ev_next;
  logic w_ev_prev;
  logic w_ev_up;
  logic w_ev_down;

  // Opposing keys landing in the same cycle cancel each other
  assign w_ev_next = w_press[0] & ~w_press[1];
  assign w_ev_prev = w_press[1] & ~w_press[0];
  assign w_ev_up   = w_press[2] & ~w_press[3];
  assign w_ev_down = w_press[3] & ~w_press[2];

  logic [2:0] rReq_q, rReq_d;
  logic [7:0] rThr_q, rThr_d;
  logic [8:0] w_thr_sum;

  assign w_thr_sum = {1'b0, rThr_q} + c_STEP9;

  always_comb begin
    rReq_d = rReq_q;
    if (w_ev_next) begin
      rReq_d = (rReq_q == 3'd5) ? 3'd1 : rReq_q + 3'd1;
    end else if (w_ev_prev) begin
      rReq_d = (rReq_q == 3'd1) ? 3'd5 : rReq_q - 3'd1;
    end

    rThr_d = rThr_q;
    if (w_ev_up) begin
      rThr_d = w_thr_sum[8] ? 8'hFF : w_thr_sum[7:0];
    end else if (w_ev_down) begin
      rThr_d = ({1'b0, rThr_q} < c_STEP9) ? 8'h00 : rThr_q - c_STEP8;
    end
  end

  logic [1:0]      st_q, st_d;
  logic [BL_W-1:0] bcnt_q, bcnt_d;
  logic            w_commit;

  // HOLD after a commit keeps a second commit out of the same blanking gap
  always_comb begin
    st_d     = st_q;
    bcnt_d   = bcnt_q;
    w_commit = 1'b0;
    case (st_q)
      c_HOLD: begin
        if (iFval) st_d = c_RUN;
      end
      c_RUN: begin
        if (!iFval) begin
          st_d   = c_BLANK;
          bcnt_d = '0;
        end
      end
      c_BLANK: begin
        if (iFval) begin
          st_d = c_RUN;
        end else if (bcnt_q == c_BL_LAST) begin
          w_commit = 1'b1;
          st_d     = c_HOLD;
          bcnt_d   = '0;
        end else begin
          bcnt_d = bcnt_q + BL_W'(1);
        end
      end
      default: begin
        st_d   = c_HOLD;
        bcnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      st_q          <= c_HOLD;
      bcnt_q        <= '0;
      rReq_q        <= 3'd1;
      rThr_q        <= c_THR0;
      oSelect       <= 3'd1;
      oThreshold    <= c_THR0;
      oSwitch_pulse <= 1'b0;
      oPending      <= 1'b0;
    end else begin
      st_q     <= st_d;
      bcnt_q   <= bcnt_d;
      rReq_q   <= rReq_d;
      rThr_q   <= rThr_d;
      oPending <= (rReq_q != oSelect) || (rThr_q != oThreshold);
      if (w_commit) begin
        oSelect       <= rReq_q;
        oThreshold    <= rThr_q;
        oSwitch_pulse <= (rReq_q != oSelect) || (rThr_q != oThreshold);
      end else begin
        oSwitch_pulse <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_mode_ctrl
// Brief    : Scenario and randomized bench for display_mode_ctrl against a
//            press-level model of the mode/threshold requests and commits.
// Revision : 1.0
// ============================================================================
module tb_display_mode_ctrl;

  localparam int DEB  = 4;
  localparam int BW   = 3;
  localparam int STEP = 8;
  localparam int INIT = 128;
  localparam int PRESS_LOW  = 8;
  localparam int PRESS_HIGH = 8;
  localparam int LONG_BLANK = 6;

  localparam logic [3:0] K_NEXT = 4'b0001;
  localparam logic [3:0] K_PREV = 4'b0010;
  localparam logic [3:0] K_UP   = 4'b0100;
  localparam logic [3:0] K_DOWN = 4'b1000;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       fval  = 1'b0;
  logic       kn = 1'b1, kp = 1'b1, ku = 1'b1, kd = 1'b1;
  logic [2:0] sel;
  logic [7:0] thr;
  logic       pulse;
  logic       pend;

  display_mode_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .BLANK_WAIT     (BW),
    .THRESH_STEP    (STEP),
    .THRESH_INIT    (INIT)
  ) dut (
    .iClk         (clk),
    .iRst_n       (rst_n),
    .iFval        (fval),
    .iKey_next    (kn),
    .iKey_prev    (kp),
    .iKey_up      (ku),
    .iKey_down    (kd),
    .oSelect      (sel),
    .oThreshold   (thr),
    .oSwitch_pulse(pulse),
    .oPending     (pend)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int mdl_req, mdl_rthr, mdl_sel, mdl_othr;
  int pulse_cnt = 0;
  bit mon_en    = 1'b0;

  logic       prev_fval = 1'b0;
  logic       prev_rst  = 1'b0;
  logic [2:0] prev_sel  = 3'd0;
  logic [7:0] prev_thr  = 8'd0;

  // Whole-run invariants: legal select, frozen outputs in frame, pulse => change
  always @(negedge clk) begin
    if (pulse === 1'b1) pulse_cnt++;
    if (mon_en && prev_rst === 1'b1) begin
      n_total++;
      if (!(int'(sel) >= 1 && int'(sel) <= 5)) $display("FAIL sel_range: oSelect=%0d required 1..5", sel); else n_pass++;
      if (prev_fval === 1'b1) begin
        n_total++;
        if (sel !== prev_sel || thr !== prev_thr)
          $display("FAIL frame_freeze: sel %0d->%0d thr %0d->%0d required unchanged", prev_sel, sel, prev_thr, thr);
        else n_pass++;
      end
      if (pulse === 1'b1) begin
        n_total++;
        if (sel === prev_sel && thr === prev_thr)
          $display("FAIL pulse_change: pulse with sel=%0d thr=%0d unchanged, required a change", sel, thr);
        else n_pass++;
      end
    end
    prev_fval <= fval;
    prev_rst  <= rst_n;
    prev_sel  <= sel;
    prev_thr  <= thr;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mdl_init();
    mdl_req = 1; mdl_rthr = INIT; mdl_sel = 1; mdl_othr = INIT;
  endtask

  task automatic mdl_keys(input logic [3:0] m);
    if (m[0] && !m[1]) mdl_req = (mdl_req % 5) + 1;
    if (m[1] && !m[0]) mdl_req = ((mdl_req + 3) % 5) + 1;
    if (m[2] && !m[3]) mdl_rthr = (mdl_rthr + STEP > 255) ? 255 : mdl_rthr + STEP;
    if (m[3] && !m[2]) mdl_rthr = (mdl_rthr - STEP < 0) ? 0 : mdl_rthr - STEP;
  endtask

  task automatic mdl_commit(output int exp_pulse);
    exp_pulse = (mdl_req != mdl_sel || mdl_rthr != mdl_othr) ? 1 : 0;
    mdl_sel  = mdl_req;
    mdl_othr = mdl_rthr;
  endtask

  task automatic press(input logic [3:0] m);
    {kd, ku, kp, kn} = ~m;
    cyc(PRESS_LOW);
    {kd, ku, kp, kn} = 4'hF;
    cyc(PRESS_HIGH);
    mdl_keys(m);
  endtask

  task automatic bounce(input logic [3:0] m);
    {kd, ku, kp, kn} = ~m;  cyc(2);
    {kd, ku, kp, kn} = 4'hF; cyc(1);
    {kd, ku, kp, kn} = ~m;  cyc(2);
    {kd, ku, kp, kn} = 4'hF; cyc(PRESS_HIGH);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    mdl_init();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fval = 1'b0; {kd, ku, kp, kn} = 4'hF;
    cyc(3);
    @(negedge clk);
    n_total++; if (sel !== 3'd1) $display("FAIL rst_sel: got %0d expected 1", sel); else n_pass++;
    n_total++; if (int'(thr) !== INIT) $display("FAIL rst_thr: got %0d expected %0d", thr, INIT); else n_pass++;
    n_total++; if (pulse !== 1'b0) $display("FAIL rst_pulse: got %b expected 0", pulse); else n_pass++;
    n_total++; if (pend !== 1'b0) $display("FAIL rst_pend: got %b expected 0", pend); else n_pass++;
    cyc(1);
    rst_n = 1'b1;
    mdl_init();
    mon_en = 1'b1;
    cyc(2);
    @(negedge clk);
    n_total++; if (int'(dut.rReq_q) !== 1) $display("FAIL rst_req: got %0d expected 1", dut.rReq_q); else n_pass++;
    n_total++; if (int'(dut.rThr_q) !== INIT) $display("FAIL rst_rthr: got %0d expected %0d", dut.rThr_q, INIT); else n_pass++;
    cyc(1);
  endtask

  task automatic test_mode_request();
    int e;
    fval = 1'b1; cyc(3);
    kn = 1'b0; cyc(10);
    kn = 1'b1; cyc(PRESS_HIGH);
    mdl_keys(K_NEXT);
    pulse_cnt = 0;
    @(negedge clk);
    n_total++; if (pend !== 1'b1) $display("FAIL req_pend_frame: got %b expected 1", pend); else n_pass++;
    n_total++; if (sel !== 3'd1) $display("FAIL req_sel_frame: got %0d expected 1", sel); else n_pass++;
    cyc(1);
    fval = 1'b0; cyc(5);
    mdl_commit(e);
    @(negedge clk);
    n_total++; if (int'(sel) !== mdl_sel) $display("FAIL req_sel_commit: got %0d expected %0d", sel, mdl_sel); else n_pass++;
    n_total++; if (pulse_cnt !== e) $display("FAIL req_pulse_cnt: got %0d expected %0d", pulse_cnt, e); else n_pass++;
    n_total++; if (pend !== 1'b0) $display("FAIL req_pend_after: got %b expected 0", pend); else n_pass++;
    cyc(1);
  endtask

  task automatic test_wrap_bounce();
    int e;
    apply_reset();
    fval = 1'b1; cyc(3);
    for (int i = 0; i < 5; i++) begin
      press(K_NEXT);
      @(negedge clk);
      n_total++; if (int'(dut.rReq_q) !== mdl_req) $display("FAIL wrap_req%0d: got %0d expected %0d", i, dut.rReq_q, mdl_req); else n_pass++;
    end
    bounce(K_NEXT);
    @(negedge clk);
    n_total++; if (int'(dut.rReq_q) !== mdl_req) $display("FAIL bounce_req: got %0d expected %0d", dut.rReq_q, mdl_req); else n_pass++;
    cyc(1);
    pulse_cnt = 0;
    fval = 1'b0; cyc(LONG_BLANK);
    mdl_commit(e);
    @(negedge clk);
    n_total++; if (int'(sel) !== mdl_sel) $display("FAIL wrap_sel: got %0d expected %0d", sel, mdl_sel); else n_pass++;
    n_total++; if (pulse_cnt !== e) $display("FAIL wrap_nochange_pulse: got %0d expected %0d", pulse_cnt, e); else n_pass++;
    cyc(1);
  endtask

  task automatic test_thresh_sat();
    int e;
    apply_reset();
    fval = 1'b1; cyc(3);
    for (int i = 0; i < 20; i++) press(K_UP);
    pulse_cnt = 0;
    fval = 1'b0; cyc(LONG_BLANK);
    mdl_commit(e);
    @(negedge clk);
    n_total++; if (int'(thr) !== 255 || mdl_othr !== 255) $display("FAIL thr_sat_hi: got %0d expected 255", thr); else n_pass++;
    n_total++; if (pulse_cnt !== e) $display("FAIL thr_hi_pulse: got %0d expected %0d", pulse_cnt, e); else n_pass++;
    cyc(1);
    fval = 1'b1; cyc(3);
    for (int i = 0; i < 40; i++) press(K_DOWN);
    fval = 1'b0; cyc(LONG_BLANK);
    mdl_commit(e);
    @(negedge clk);
    n_total++; if (int'(thr) !== 0 || mdl_othr !== 0) $display("FAIL thr_sat_lo: got %0d expected 0", thr); else n_pass++;
    cyc(1);
  endtask

  task automatic test_short_blank();
    int e;
    apply_reset();
    fval = 1'b1; cyc(3);
    press(K_PREV);
    pulse_cnt = 0;
    fval = 1'b0; cyc(2);
    fval = 1'b1; cyc(4);
    @(negedge clk);
    n_total++; if (pulse_cnt !== 0) $display("FAIL short_pulse: got %0d expected 0", pulse_cnt); else n_pass++;
    n_total++; if (int'(sel) !== mdl_sel) $display("FAIL short_sel: got %0d expected %0d", sel, mdl_sel); else n_pass++;
    n_total++; if (pend !== 1'b1) $display("FAIL short_pend: got %b expected 1", pend); else n_pass++;
    cyc(1);
    fval = 1'b0; cyc(LONG_BLANK);
    mdl_commit(e);
    @(negedge clk);
    n_total++; if (int'(sel) !== 5) $display("FAIL short_next_sel: got %0d expected 5", sel); else n_pass++;
    n_total++; if (pulse_cnt !== e) $display("FAIL short_next_pulse: got %0d expected %0d", pulse_cnt, e); else n_pass++;
    cyc(1);
  endtask

  task automatic test_commit_overlap();
    int e;
    apply_reset();
    fval = 1'b1; cyc(3);
    press(K_NEXT);
    pulse_cnt = 0;
    // Key edge timed so its press event coincides with the commit cycle
    kn = 1'b0; cyc(3);
    fval = 1'b0; cyc(5);
    kn = 1'b1; cyc(2);
    mdl_commit(e);
    mdl_keys(K_NEXT);
    @(negedge clk);
    n_total++; if (sel !== 3'd2) $display("FAIL overlap_sel: got %0d expected 2", sel); else n_pass++;
    n_total++; if (int'(dut.rReq_q) !== mdl_req) $display("FAIL overlap_req: got %0d expected %0d", dut.rReq_q, mdl_req); else n_pass++;
    n_total++; if (pend !== 1'b1) $display("FAIL overlap_pend: got %b expected 1", pend); else n_pass++;
    n_total++; if (pulse_cnt !== e) $display("FAIL overlap_pulse: got %0d expected %0d", pulse_cnt, e); else n_pass++;
    cyc(PRESS_HIGH);
    fval = 1'b1; cyc(3);
    fval = 1'b0; cyc(LONG_BLANK);
    mdl_commit(e);
    @(negedge clk);
    n_total++; if (int'(sel) !== mdl_sel) $display("FAIL overlap_next_sel: got %0d expected %0d", sel, mdl_sel); else n_pass++;
    cyc(1);
  endtask

  task automatic test_reset_midblank();
    apply_reset();
    fval = 1'b1; cyc(3);
    press(K_NEXT);
    press(K_UP);
    pulse_cnt = 0;
    fval = 1'b0; cyc(2);
    rst_n = 1'b0; cyc(1);
    rst_n = 1'b1;
    mdl_init();
    @(negedge clk);
    n_total++; if (sel !== 3'd1) $display("FAIL midblank_sel: got %0d expected 1", sel); else n_pass++;
    n_total++; if (pend !== 1'b0) $display("FAIL midblank_pend: got %b expected 0", pend); else n_pass++;
    cyc(LONG_BLANK);
    @(negedge clk);
    n_total++; if (pulse_cnt !== 0) $display("FAIL midblank_pulse: got %0d expected 0", pulse_cnt); else n_pass++;
    n_total++; if (sel !== 3'd1 || int'(thr) !== INIT) $display("FAIL midblank_out: got sel %0d thr %0d expected 1/%0d", sel, thr, INIT); else n_pass++;
    cyc(1);
  endtask

  task automatic test_reset_held_key();
    kn = 1'b0;
    apply_reset();
    cyc(DEB + 1);
    @(negedge clk);
    n_total++; if (int'(dut.rReq_q) !== 1) $display("FAIL held_early: got %0d expected 1", dut.rReq_q); else n_pass++;
    cyc(8);
    kn = 1'b1; cyc(PRESS_HIGH);
    mdl_keys(K_NEXT);
    @(negedge clk);
    n_total++; if (int'(dut.rReq_q) !== mdl_req) $display("FAIL held_event: got %0d expected %0d", dut.rReq_q, mdl_req); else n_pass++;
    cyc(1);
  endtask

  task automatic test_simultaneous();
    int e;
    apply_reset();
    fval = 1'b1; cyc(3);
    press(K_NEXT | K_PREV);
    @(negedge clk);
    n_total++; if (int'(dut.rReq_q) !== mdl_req) $display("FAIL simul_np_a: got %0d expected %0d", dut.rReq_q, mdl_req); else n_pass++;
    press(K_NEXT);
    press(K_NEXT | K_PREV);
    @(negedge clk);
    n_total++; if (int'(dut.rReq_q) !== mdl_req) $display("FAIL simul_np_b: got %0d expected %0d", dut.rReq_q, mdl_req); else n_pass++;
    press(K_UP);
    press(K_UP | K_DOWN);
    @(negedge clk);
    n_total++; if (int'(dut.rThr_q) !== mdl_rthr) $display("FAIL simul_ud: got %0d expected %0d", dut.rThr_q, mdl_rthr); else n_pass++;
    cyc(1);
    fval = 1'b0; cyc(LONG_BLANK);
    mdl_commit(e);
    @(negedge clk);
    n_total++; if (int'(sel) !== mdl_sel || int'(thr) !== mdl_othr)
      $display("FAIL simul_commit: got sel %0d thr %0d expected %0d/%0d", sel, thr, mdl_sel, mdl_othr); else n_pass++;
    cyc(1);
  endtask

  task automatic test_random();
    int e;
    int n;
    int a;
    logic [3:0] bm;
    apply_reset();
    for (int it = 0; it < 25; it++) begin
      fval = 1'b1; cyc(3);
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) begin
        a = $urandom_range(0, 6);
        case (a)
          0: press(K_NEXT);
          1: press(K_PREV);
          2: press(K_UP);
          3: press(K_DOWN);
          4: press(K_NEXT | K_PREV);
          5: press(K_UP | K_DOWN);
          default: begin
            bm = 4'b0001 << $urandom_range(0, 3);
            bounce(bm);
          end
        endcase
      end
      @(negedge clk);
      e = (mdl_req != mdl_sel || mdl_rthr != mdl_othr) ? 1 : 0;
      n_total++; if (int'(pend) !== e) $display("FAIL rnd_pend it%0d: got %b expected %0d", it, pend, e); else n_pass++;
      cyc(1);
      pulse_cnt = 0;
      if ($urandom_range(0, 2) == 0) begin
        fval = 1'b0; cyc(2);
        fval = 1'b1; cyc(3);
        @(negedge clk);
        n_total++; if (pulse_cnt !== 0 || int'(sel) !== mdl_sel || int'(thr) !== mdl_othr)
          $display("FAIL rnd_short it%0d: got pulses %0d sel %0d thr %0d expected 0/%0d/%0d", it, pulse_cnt, sel, thr, mdl_sel, mdl_othr);
        else n_pass++;
      end else begin
        fval = 1'b0; cyc(LONG_BLANK);
        mdl_commit(e);
        @(negedge clk);
        n_total++; if (pulse_cnt !== e || int'(sel) !== mdl_sel || int'(thr) !== mdl_othr)
          $display("FAIL rnd_commit it%0d: got pulses %0d sel %0d thr %0d expected %0d/%0d/%0d", it, pulse_cnt, sel, thr, e, mdl_sel, mdl_othr);
        else n_pass++;
        n_total++; if (pend !== 1'b0) $display("FAIL rnd_pend_after it%0d: got %b expected 0", it, pend); else n_pass++;
      end
      cyc(1);
    end
  endtask

  initial begin
    mdl_init();
    test_reset();
    test_mode_request();
    test_wrap_bounce();
    test_thresh_sat();
    test_short_blank();
    test_commit_overlap();
    test_reset_midblank();
    test_reset_held_key();
    test_simultaneous();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
